// File: rtl/wrr_packet_scheduler_pkg.sv
// Shared definitions for the weighted round-robin packet scheduler.
//   wrr_state_e  : scheduler FSM states (idle, one-cycle arbitration, packet lock)
//   id_width     : grant-id width for a given requester count
//   turn_quota   : extra packets granted in a turn for a given weight (weight 0 acts as 1)
package wrr_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArb  = 2'd1,
    StLock = 2'd2
  } wrr_state_e;

  localparam int unsigned MinRequesters = 2;
  localparam int unsigned MaxRequesters = 16;

  // Width of an id able to address n requesters; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // A turn always carries at least one packet, so the remaining quota after the
  // first packet is max(weight, 1) - 1.
  function automatic int unsigned turn_quota(input int unsigned weight);
    return (weight == 0) ? 0 : weight - 1;
  endfunction

endpackage

// File: rtl/wrr_packet_scheduler_picker.sv
// Circular first-one selector.
// Scans the request mask starting at ptr_i + 1, wrapping past NumReq - 1 to 0,
// and returns the first set position. Purely combinational.
//   req_i   : request mask, one bit per requester
//   ptr_i   : id of the previous winner; the scan starts just after it
//   id_o    : selected requester id (0 when nothing is requested)
//   found_o : at least one request bit is set
module rr_priority_picker
  import wrr_packet_scheduler_pkg::*;
#(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdWidth = 1
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic [IdWidth-1:0] id_o,
  output logic               found_o
);

  // One extra bit holds ptr + offset before the wrap correction.
  localparam int unsigned IdxW = IdWidth + 1;

  logic [IdxW-1:0] idx;

  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    idx     = '0;
    // Offsets 1..NumReq visit every requester once, the previous winner last.
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = {1'b0, ptr_i} + IdxW'(i);
      if (idx >= IdxW'(NumReq)) begin
        idx = idx - IdxW'(NumReq);
      end
      // The range guard keeps ids >= NumReq out even for non-power-of-2 counts.
      if (!found_o && (idx < IdxW'(NumReq)) && req_i[idx]) begin
        found_o = 1'b1;
        id_o    = idx[IdWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_packet_scheduler.sv
// Weighted round-robin packet scheduler for one shared output stream port.
// Requesters own the port for whole packets; a requester may keep the port for
// up to max(weight, 1) consecutive packets (a "turn") before the round-robin
// pointer moves on. Every packet boundary costs exactly one arbitration cycle.
//   clk_i         : clock, rising edge
//   rst_in        : asynchronous active-low reset
//   s_valid_i     : per-requester TVALID
//   s_last_i      : per-requester TLAST
//   weight_i      : per-requester packets-per-turn, sampled at turn start
//   m_ready_i     : output-port TREADY
//   grant_o       : owning requester id (datapath mux select), registered
//   grant_valid_o : port is owned and grant_o is meaningful, registered
//   s_ready_o     : per-requester TREADY, only the owner sees m_ready_i
//   m_valid_o     : output-port TVALID
//   m_last_o      : output-port TLAST
module wrr_packet_scheduler
  import wrr_packet_scheduler_pkg::*;
#(
  parameter  int unsigned S_DATA_COUNT = 2,
  parameter  int unsigned WEIGHT_WIDTH = 4,
  localparam int unsigned T_ID___WIDTH = id_width(S_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic [WEIGHT_WIDTH-1:0] weight_i [S_DATA_COUNT],
  input  logic                    m_ready_i,
  output logic [T_ID___WIDTH-1:0] grant_o,
  output logic                    grant_valid_o,
  output logic [S_DATA_COUNT-1:0] s_ready_o,
  output logic                    m_valid_o,
  output logic                    m_last_o
);

  // Pointer reset value gives requester 0 first priority.
  localparam logic [T_ID___WIDTH-1:0] PtrReset = T_ID___WIDTH'(S_DATA_COUNT - 1);

  wrr_state_e              state_q, state_d;
  logic [T_ID___WIDTH-1:0] grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [T_ID___WIDTH-1:0] cur_q, cur_d;
  logic [WEIGHT_WIDTH-1:0] quota_q, quota_d;

  logic [T_ID___WIDTH-1:0] pick_id;
  logic                    pick_found;
  logic [WEIGHT_WIDTH-1:0] pick_weight;
  logic                    in_lock;
  logic                    keep_turn;
  logic                    own_valid;
  logic                    own_last;
  logic                    last_xfer;

  rr_priority_picker #(
    .NumReq  (S_DATA_COUNT),
    .IdWidth (T_ID___WIDTH)
  ) u_picker (
    .req_i   (s_valid_i),
    .ptr_i   (ptr_q),
    .id_o    (pick_id),
    .found_o (pick_found)
  );

  assign in_lock     = (state_q == StLock);
  assign pick_weight = weight_i[pick_id];
  assign own_valid   = s_valid_i[grant_q];
  assign own_last    = s_last_i[grant_q];

  // The current turn continues only while quota remains and its owner still asks.
  assign keep_turn = (quota_q != '0) && s_valid_i[cur_q];

  // End of packet: a handshake on the owner's TLAST beat.
  assign last_xfer = in_lock && own_valid && m_ready_i && own_last;

  // Handshake steering: everything is gated on LOCK so reset and idle are quiet.
  always_comb begin
    s_ready_o = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    if (in_lock) begin
      s_ready_o[grant_q] = m_ready_i;
      m_valid_o          = own_valid;
      m_last_o           = own_last;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    cur_d         = cur_q;
    quota_d       = quota_q;

    unique case (state_q)
      StIdle: begin
        if (|s_valid_i) begin
          state_d = StArb;
        end
      end

      StArb: begin
        if (keep_turn) begin
          grant_d       = cur_q;
          grant_valid_d = 1'b1;
          quota_d       = quota_q - WEIGHT_WIDTH'(1);
          state_d       = StLock;
        end else if (pick_found) begin
          // New turn: weight is sampled here and nowhere else.
          grant_d       = pick_id;
          grant_valid_d = 1'b1;
          ptr_d         = pick_id;
          cur_d         = pick_id;
          quota_d       = WEIGHT_WIDTH'(turn_quota(32'(pick_weight)));
          state_d       = StLock;
        end else begin
          // Requests vanished: go quiet without moving the pointer.
          state_d = StIdle;
        end
      end

      StLock: begin
        // A dropped owner valid mid-packet just stalls; the grant is never revoked.
        if (last_xfer) begin
          grant_valid_d = 1'b0;
          state_d       = StArb;
        end
      end

      default: begin
        state_d       = StIdle;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= PtrReset;
      cur_q         <= '0;
      quota_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      cur_q         <= cur_d;
      quota_q       <= quota_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;

endmodule

// File: tb/tb_wrr_packet_scheduler.sv
// Directed bench for wrr_packet_scheduler with three requesters (non-power-of-2,
// exercises wrap-around). Requester 2 stays idle unless stated otherwise.
module tb_wrr_packet_scheduler;

  localparam int unsigned S  = 3;
  localparam int unsigned WW = 4;
  localparam int unsigned IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_in;
  logic [S-1:0]  s_valid_i;
  logic [S-1:0]  s_last_i;
  logic [WW-1:0] weight_i [S];
  logic          m_ready_i;
  logic [IW-1:0] grant_o;
  logic          grant_valid_o;
  logic [S-1:0]  s_ready_o;
  logic          m_valid_o;
  logic          m_last_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  wrr_packet_scheduler #(
    .S_DATA_COUNT (S),
    .WEIGHT_WIDTH (WW)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_in        (rst_in),
    .s_valid_i     (s_valid_i),
    .s_last_i      (s_last_i),
    .weight_i      (weight_i),
    .m_ready_i     (m_ready_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .s_ready_o     (s_ready_o),
    .m_valid_o     (m_valid_o),
    .m_last_o      (m_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves time 1 ns after a rising edge, so inputs change away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called in the first LOCK cycle of a packet; returns in the ARB gap cycle.
  task automatic run_packet(input string tag, input int unsigned g, input int unsigned beats);
    for (int unsigned b = 1; b <= beats; b++) begin
      s_last_i = (b == beats) ? '1 : '0;
      #1;
      check({tag, "_gv"}, 32'(grant_valid_o), 32'(1));
      check({tag, "_grant"}, 32'(grant_o), g);
      check({tag, "_mvalid"}, 32'(m_valid_o), 32'(1));
      check({tag, "_mlast"}, 32'(m_last_o), (b == beats) ? 32'(1) : 32'(0));
      check({tag, "_sready"}, 32'(s_ready_o), 32'(1) << g);
      step();
    end
    s_last_i = '0;
    #1;
    check({tag, "_gap"}, 32'(grant_valid_o), 32'(0));
  endtask

  int unsigned seq37 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic        rdy38 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        lst38 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_in    = 1'b0;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b0;
    for (int i = 0; i < int'(S); i++) weight_i[i] = WW'(1);

    // Reset state; combinational outputs stay low even with live inputs.
    #2;
    check("rst_gv", 32'(grant_valid_o), 32'(0));
    check("rst_grant", 32'(grant_o), 32'(0));
    s_valid_i = '1;
    s_last_i  = '1;
    m_ready_i = 1'b1;
    #1;
    check("rst_sready", 32'(s_ready_o), 32'(0));
    check("rst_mvalid", 32'(m_valid_o), 32'(0));
    check("rst_mlast", 32'(m_last_o), 32'(0));
    s_valid_i = '0;
    s_last_i  = '0;
    step();
    step();
    rst_in = 1'b1;

    // Equal weights, 4-beat packets: 0,1,0,1 with one ARB cycle between packets.
    s_valid_i = 3'b011;
    step();
    check("r36_arb", 32'(grant_valid_o), 32'(0));
    step();
    run_packet("r36_p0", 0, 4);
    step();
    run_packet("r36_p1", 1, 4);
    step();
    run_packet("r36_p2", 0, 4);
    step();
    run_packet("r36_p3", 1, 4);
    s_valid_i = '0;
    step();
    check("r36_idle", 32'(grant_valid_o), 32'(0));

    // Weights 3:1, single-beat packets.
    weight_i[0] = WW'(3);
    weight_i[1] = WW'(1);
    s_valid_i   = 3'b011;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      run_packet($sformatf("r37_%0d", i), seq37[i], 1);
    end
    s_valid_i = '0;
    step();

    // Back-pressure: TLAST seen with ready low must not release the grant.
    weight_i[0] = WW'(1);
    s_valid_i   = 3'b011;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      m_ready_i = rdy38[i];
      s_last_i  = lst38[i] ? '1 : '0;
      #1;
      check($sformatf("r38_grant_%0d", i), 32'(grant_o), 32'(0));
      check($sformatf("r38_gv_%0d", i), 32'(grant_valid_o), 32'(1));
      check($sformatf("r38_sready_%0d", i), 32'(s_ready_o), rdy38[i] ? 32'(1) : 32'(0));
      check($sformatf("r38_mlast_%0d", i), 32'(m_last_o), lst38[i] ? 32'(1) : 32'(0));
      step();
    end
    m_ready_i = 1'b1;
    s_last_i  = '0;
    #1;
    check("r38_release", 32'(grant_valid_o), 32'(0));
    s_valid_i = '0;
    step();

    // Asynchronous reset on beat 2 of a 5-beat packet (owner is requester 1).
    s_valid_i = 3'b011;
    step();
    step();
    #1;
    check("r40_pre_grant", 32'(grant_o), 32'(1));
    step();
    #1;
    rst_in = 1'b0;
    #1;
    check("r40_async_gv", 32'(grant_valid_o), 32'(0));
    check("r40_async_grant", 32'(grant_o), 32'(0));
    check("r40_async_mvalid", 32'(m_valid_o), 32'(0));
    check("r40_async_sready", 32'(s_ready_o), 32'(0));
    step();
    rst_in = 1'b1;
    step();
    check("r40_arb", 32'(grant_valid_o), 32'(0));
    step();
    check("r40_restart_grant", 32'(grant_o), 32'(0));
    check("r40_restart_gv", 32'(grant_valid_o), 32'(1));
    rst_in = 1'b0;
    #1;
    s_valid_i = '0;
    step();
    rst_in = 1'b1;

    // Pointer at 2, only requester 1 valid; requester 0 joins mid-packet and
    // wins next via wrap-around. One beat has the owner's valid dropped.
    s_valid_i = 3'b010;
    step();
    step();
    #1;
    check("r39_grant", 32'(grant_o), 32'(1));
    step();
    s_valid_i = 3'b011;
    #1;
    check("r39_hold_grant", 32'(grant_o), 32'(1));
    check("r39_hold_sready", 32'(s_ready_o), 32'(2));
    step();
    s_valid_i = 3'b001;
    #1;
    check("r39_drop_mvalid", 32'(m_valid_o), 32'(0));
    check("r39_drop_grant", 32'(grant_o), 32'(1));
    step();
    s_valid_i = 3'b011;
    s_last_i  = '1;
    #1;
    check("r39_last_mvalid", 32'(m_valid_o), 32'(1));
    check("r39_last_mlast", 32'(m_last_o), 32'(1));
    step();
    s_last_i = '0;
    #1;
    check("r39_gap", 32'(grant_valid_o), 32'(0));
    step();
    run_packet("r39_wrap", 0, 1);

    // Weight 0 behaves as 1: requester 1 alone keeps getting one packet per turn,
    // and yields to requester 0 as soon as it asks.
    s_valid_i   = 3'b010;
    weight_i[1] = WW'(0);
    step();
    for (int i = 0; i < 3; i++) begin
      run_packet($sformatf("r41_%0d", i), 1, 2);
      step();
    end
    s_valid_i = 3'b011;
    run_packet("r41_share", 1, 2);
    step();
    run_packet("r41_next", 0, 1);
    s_valid_i = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
